// File: rtl/ins_queue.sv
// Instruction queue between fetch and decode: a 16-entry circular FIFO of {ins, pc}
// that issues at most one instruction per cycle, in order, when the ROB and the target unit can accept it.
module ins_queue #(
    parameter int DEPTH_LOG = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr,
    input  logic        fetch_vld,
    input  logic [31:0] fetch_ins,
    input  logic [31:0] fetch_pc,
    output logic        fetch_full,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        iss_flg,
    output logic [31:0] iss_ins,
    output logic [31:0] iss_pc,
    output logic        iss_to_lsb
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT   = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [DEPTH_LOG:0] ALMOST_CNT = FULL_CNT - 1'b1;

    logic [31:0] ins_mem [DEPTH];
    logic [31:0] pc_mem  [DEPTH];

    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 iss_flg_q, iss_flg_d;
    logic [31:0]          iss_ins_q, iss_ins_d;
    logic [31:0]          iss_pc_q, iss_pc_d;
    logic                 iss_to_lsb_q, iss_to_lsb_d;

    logic [31:0] head_ins;
    logic        head_is_mem;
    logic        push_en;
    logic        pop_en;

    assign head_ins    = ins_mem[head_q];
    assign head_is_mem = (head_ins[6:0] == 7'b0000011) || (head_ins[6:0] == 7'b0100011);

    // One slot of slack covers a fetch already in flight when this rises.
    assign fetch_full = (count_q >= ALMOST_CNT);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        iss_flg_d    = 1'b0;
        iss_ins_d    = iss_ins_q;
        iss_pc_d     = iss_pc_q;
        iss_to_lsb_d = iss_to_lsb_q;
        push_en      = 1'b0;
        pop_en       = 1'b0;

        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            push_en = fetch_vld && (count_q != FULL_CNT);
            pop_en  = (count_q != '0) && !rob_full && (head_is_mem ? !lsb_full : !rs_full);

            if (push_en) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop_en) begin
                head_d       = head_q + 1'b1;
                iss_flg_d    = 1'b1;
                iss_ins_d    = head_ins;
                iss_pc_d     = pc_mem[head_q];
                iss_to_lsb_d = head_is_mem;
            end
            if (push_en && !pop_en) begin
                count_d = count_q + 1'b1;
            end else if (pop_en && !push_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            iss_flg_q    <= 1'b0;
            iss_ins_q    <= '0;
            iss_pc_q     <= '0;
            iss_to_lsb_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            iss_flg_q    <= iss_flg_d;
            iss_ins_q    <= iss_ins_d;
            iss_pc_q     <= iss_pc_d;
            iss_to_lsb_q <= iss_to_lsb_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so contents never need clearing.
    always_ff @(posedge clk_in) begin
        if (push_en) begin
            ins_mem[tail_q] <= fetch_ins;
            pc_mem[tail_q]  <= fetch_pc;
        end
    end

    assign iss_flg    = iss_flg_q;
    assign iss_ins    = iss_ins_q;
    assign iss_pc     = iss_pc_q;
    assign iss_to_lsb = iss_to_lsb_q;

endmodule

// File: tb/tb_ins_queue.sv
// Self-checking bench for ins_queue: a behavioural queue model predicts issues into a scoreboard
// that is drained whenever the DUT raises iss_flg.
module tb_ins_queue;

    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] LW  = 32'h0000A103;
    localparam logic [31:0] SW  = 32'h0020A023;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clr = 1'b0;
    logic        fetch_vld = 1'b0;
    logic [31:0] fetch_ins = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_full;
    logic        rob_full = 1'b0;
    logic        rs_full = 1'b0;
    logic        lsb_full = 1'b0;
    logic        iss_flg;
    logic [31:0] iss_ins;
    logic [31:0] iss_pc;
    logic        iss_to_lsb;

    int errors = 0;
    int checks = 0;
    int n_issued = 0;

    entry_t mq[$];
    entry_t sb[$];
    entry_t last_iss = '{32'h0, 32'h0};
    logic   exp_flg = 1'b0;

    ins_queue #(.DEPTH_LOG(4)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clr        (clr),
        .fetch_vld  (fetch_vld),
        .fetch_ins  (fetch_ins),
        .fetch_pc   (fetch_pc),
        .fetch_full (fetch_full),
        .rob_full   (rob_full),
        .rs_full    (rs_full),
        .lsb_full   (lsb_full),
        .iss_flg    (iss_flg),
        .iss_ins    (iss_ins),
        .iss_pc     (iss_pc),
        .iss_to_lsb (iss_to_lsb)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic is_mem(input logic [31:0] ins);
        return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, predict the edge, then check #1 after the posedge.
    task automatic step(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rob, input logic rs, input logic lsb,
                        input logic rdy, input logic c);
        logic   do_push;
        logic   do_pop;
        entry_t e;
        fetch_vld = vld;
        fetch_ins = ins;
        fetch_pc  = pc;
        rob_full  = rob;
        rs_full   = rs;
        lsb_full  = lsb;
        rdy_in    = rdy;
        clr       = c;

        exp_flg = 1'b0;
        if (c) begin
            mq.delete();
        end else if (rdy) begin
            do_push = vld && (mq.size() != 16);
            do_pop  = (mq.size() != 0) && !rob &&
                      (is_mem(mq[0].ins) ? !lsb : !rs);
            if (do_pop) begin
                sb.push_back(mq.pop_front());
                exp_flg = 1'b1;
            end
            if (do_push) mq.push_back('{ins, pc});
        end

        @(posedge clk_in);
        #1;
        check("iss_flg", {63'b0, iss_flg}, {63'b0, exp_flg});
        check("fetch_full", {63'b0, fetch_full}, {63'b0, mq.size() >= 15});
        if (iss_flg) begin
            if (sb.size() == 0) begin
                check("spurious_issue", {63'b0, iss_flg}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("iss_ins", {32'b0, iss_ins}, {32'b0, e.ins});
                check("iss_pc", {32'b0, iss_pc}, {32'b0, e.pc});
                check("iss_to_lsb", {63'b0, iss_to_lsb}, {63'b0, is_mem(e.ins)});
                last_iss = e;
                n_issued++;
            end
        end else begin
            check("hold_ins", {32'b0, iss_ins}, {32'b0, last_iss.ins});
            check("hold_pc", {32'b0, iss_pc}, {32'b0, last_iss.pc});
        end
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int st;
        logic [31:0] ins_pick;

        #2;
        check("rst_iss_flg", {63'b0, iss_flg}, 64'h0);
        check("rst_iss_ins", {32'b0, iss_ins}, 64'h0);
        check("rst_iss_pc", {32'b0, iss_pc}, 64'h0);
        check("rst_iss_to_lsb", {63'b0, iss_to_lsb}, 64'h0);
        check("rst_fetch_full", {63'b0, fetch_full}, 64'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Reset then idle
        idle(10);

        // Single ADD: issues one cycle after the edge following its push
        step(1'b1, ADD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        base = n_issued;
        idle(3);
        check("single_add_issues", 64'(n_issued - base), 64'd1);

        // Routing stall: LW at head blocked by lsb_full holds the ADD behind it
        step(1'b1, LW, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, ADD, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        base = n_issued;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stall_no_issue", 64'(n_issued - base), 64'd0);
        idle(3);
        check("stall_released", 64'(n_issued - base), 64'd2);

        // Fill with rob_full: 17th fetch dropped, then drain with a dropped push on the full pop cycle
        for (int i = 0; i < 17; i++)
            step(1'b1, (i % 3 == 1) ? SW : ADD, 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fill_fetch_full", {63'b0, fetch_full}, 64'h1);
        base = n_issued;
        step(1'b1, ADD, 32'hDEAD0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(18);
        check("fill_issue_count", 64'(n_issued - base), 64'd16);
        check("fill_last_pc", {32'b0, iss_pc}, 64'h3C);

        // Flush: 8 queued entries and a coincident fetch are discarded
        for (int i = 0; i < 8; i++)
            step(1'b1, ADD, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, ADD, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        base = n_issued;
        idle(3);
        check("flush_no_issue", 64'(n_issued - base), 64'd0);
        step(1'b1, LW, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("flush_new_pc", {32'b0, iss_pc}, 64'h400);

        // rdy_in low mid-stream freezes everything
        for (int i = 0; i < 4; i++)
            step(1'b1, ADD, 32'h500 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        base = n_issued;
        for (int i = 0; i < 5; i++)
            step(1'b1, SW, 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rdy_low_no_issue", 64'(n_issued - base), 64'd0);
        idle(6);
        check("rdy_resume_count", 64'(n_issued - base), 64'd4);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            st = int'($urandom_range(0, 2));
            ins_pick = (st == 0) ? ADD : ((st == 1) ? LW : SW);
            step($urandom_range(0, 3) != 0, ins_pick | (32'($urandom) & 32'hFFFFFF80),
                 32'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 40) == 0);
        end

        // Async reset while the queue is nearly full and outputs are non-zero
        for (int i = 0; i < 16; i++)
            step(1'b1, ADD, 32'h700 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_vld = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check("async_iss_flg", {63'b0, iss_flg}, 64'h0);
        check("async_iss_ins", {32'b0, iss_ins}, 64'h0);
        check("async_iss_pc", {32'b0, iss_pc}, 64'h0);
        check("async_iss_to_lsb", {63'b0, iss_to_lsb}, 64'h0);
        check("async_fetch_full", {63'b0, fetch_full}, 64'h0);
        mq.delete();
        sb.delete();
        last_iss = '{32'h0, 32'h0};
        @(negedge clk_in);
        rst_in = 1'b0;
        step(1'b1, SW, 32'h800, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("post_reset_pc", {32'b0, iss_pc}, 64'h800);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
